bcd_field_editor: RTL and testbench

//  Parametrised successor of the RTC user-control FSM. Edits N_FIELDS packed 8-bit BCD fields

---
 rtl/bcd_field_editor_if.sv | 27 ++
 rtl/bcd_field_editor.sv | 200 ++++++++++++++++++++
 tb/tb_bcd_field_editor.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_field_editor_if.sv
// Board-side bundle for bcd_field_editor: debounced buttons and mode switch in,
// packed BCD fields and editor status out.
interface bcd_field_editor_if #(
  parameter int N_FIELDS = 9
);
  logic                  BTNP;
  logic                  BTNR;
  logic                  BTNL;
  logic                  BTNU;
  logic                  BTND;
  logic                  CTRL_Switch;
  logic [8*N_FIELDS-1:0] fields_o;
  logic [2:0]            state_o;
  logic [3:0]            field_idx_o;
  logic                  editing_o;
  logic                  commit_o;

  modport master (
    output BTNP, BTNR, BTNL, BTNU, BTND, CTRL_Switch,
    input  fields_o, state_o, field_idx_o, editing_o, commit_o
  );

  modport slave (
    input  BTNP, BTNR, BTNL, BTNU, BTND, CTRL_Switch,
    output fields_o, state_o, field_idx_o, editing_o, commit_o
  );
endinterface

// File: rtl/bcd_field_editor.sv
// Push-button editor for packed BCD fields split into a clock group and a timer group,
// with edge detection, held-button auto-repeat and a one-cycle commit strobe.
module bcd_field_editor #(
  parameter int                    N_FIELDS    = 9,
  parameter int                    SPLIT       = 6,
  parameter logic [8*N_FIELDS-1:0] FIELD_MIN   = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                                  8'h00, 8'h00, 8'h01, 8'h01},
  parameter logic [8*N_FIELDS-1:0] FIELD_MAX   = {8'h59, 8'h59, 8'h23, 8'h59, 8'h59,
                                                  8'h23, 8'h99, 8'h12, 8'h31},
  parameter logic [8*N_FIELDS-1:0] FIELD_RST   = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                                  8'h00, 8'h00, 8'h01, 8'h01},
  parameter logic [15:0]           REPEAT_DLY  = 16'd50000,
  parameter logic [15:0]           REPEAT_RATE = 16'd10000
) (
  input  logic              clk,
  input  logic              reset,
  bcd_field_editor_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEL    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_EDIT   = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

  typedef struct packed {
    logic p;
    logic r;
    logic l;
    logic u;
    logic d;
  } btn_t;

  localparam logic [3:0] GRP0_FIRST = 4'd0;
  localparam logic [3:0] GRP0_LAST  = 4'(SPLIT - 1);
  localparam logic [3:0] GRP1_FIRST = 4'(SPLIT);
  localparam logic [3:0] GRP1_LAST  = 4'(N_FIELDS - 1);

  state_t                   state_q;
  state_t                   state_d;
  btn_t                     btn_q;
  btn_t                     btn_prev;
  btn_t                     evt;
  logic                     grp;
  logic [3:0]               field_idx;
  logic [3:0]               grp_first;
  logic [3:0]               grp_last;
  logic [N_FIELDS-1:0][7:0] fields_q;
  logic [15:0]              rep_cnt;
  logic [15:0]              rep_cnt_d;
  logic                     rep_phase;
  logic                     rep_phase_d;
  logic                     step_en;
  logic                     step_up;
  logic [7:0]               cur_f;
  logic [7:0]               cur_min;
  logic [7:0]               cur_max;
  logic [7:0]               stepped;
  logic                     editing;
  logic                     commit;

  // One BCD increment/decrement with wrap at the field's own bounds.
  function automatic logic [7:0] bcd_step(input logic [7:0] f, input logic [7:0] mn,
                                          input logic [7:0] mx, input logic up);
    logic [7:0] r;
    if (up) begin
      if (f == mx)              r = mn;
      else if (f[3:0] == 4'h9) r = f + 8'h07;
      else                      r = f + 8'h01;
    end else begin
      if (f == mn)              r = mx;
      else if (f[3:0] == 4'h0) r = f - 8'h07;
      else                      r = f - 8'h01;
    end
    return r;
  endfunction

  assign evt       = btn_t'(btn_q & ~btn_prev);
  assign grp_first = grp ? GRP1_FIRST : GRP0_FIRST;
  assign grp_last  = grp ? GRP1_LAST  : GRP0_LAST;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:   state_d = evt.p ? ST_SEL : ST_IDLE;
      ST_SEL:    state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_EDIT;
      ST_EDIT:   state_d = evt.p ? ST_COMMIT : ST_EDIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    editing = (state_q == ST_LOAD) || (state_q == ST_EDIT);
    commit  = (state_q == ST_COMMIT);
  end

  // Step generation: an edge steps at once; a held button steps again REPEAT_DLY
  // cycles after its edge step, then every REPEAT_RATE cycles.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    step_en     = 1'b0;
    step_up     = btn_q.u;
    rep_cnt_d   = '0;
    rep_phase_d = 1'b0;
    if (state_q == ST_EDIT && !evt.p && !evt.r && !evt.l) begin
      if (btn_q.u && btn_q.d) begin
        step_en = 1'b0;
      end else if (evt.u || evt.d) begin
        step_en   = 1'b1;
        rep_cnt_d = 16'd1;
      end else if (btn_q.u || btn_q.d) begin
        if ((!rep_phase && rep_cnt == REPEAT_DLY) || (rep_phase && rep_cnt == REPEAT_RATE)) begin
          step_en     = 1'b1;
          rep_cnt_d   = 16'd1;
          rep_phase_d = 1'b1;
        end else begin
          rep_cnt_d   = rep_cnt + 16'd1;
          rep_phase_d = rep_phase;
        end
      end
    end
  end

  // Selected field and its bounds
  always_comb begin
    cur_f   = '0;
    cur_min = '0;
    cur_max = '0;
    for (int k = 0; k < N_FIELDS; k++) begin
      if (field_idx == 4'(k)) begin
        cur_f   = fields_q[k];
        cur_min = FIELD_MIN[8*k +: 8];
        cur_max = FIELD_MAX[8*k +: 8];
      end
    end
    stepped = bcd_step(cur_f, cur_min, cur_max, step_up);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_q     <= '0;
      btn_prev  <= '0;
      grp       <= 1'b0;
      field_idx <= '0;
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
      // NOTE: the field store is a handful of flops, not a RAM, so it is reset to the
      // load values; an aborted edit must leave known values behind.
      fields_q  <= FIELD_RST;
    end else begin
      // NOTE: non-blocking assignments throughout, so btn_prev takes the old btn_q.
      btn_q     <= '{p: bus.BTNP, r: bus.BTNR, l: bus.BTNL, u: bus.BTNU, d: bus.BTND};
      btn_prev  <= btn_q;
      rep_cnt   <= rep_cnt_d;
      rep_phase <= rep_phase_d;
      case (state_q)
        ST_SEL: begin
          grp       <= bus.CTRL_Switch;
          field_idx <= bus.CTRL_Switch ? GRP1_FIRST : GRP0_FIRST;
        end
        ST_LOAD: begin
          for (int k = 0; k < N_FIELDS; k++) begin
            if (grp ? (k >= SPLIT) : (k < SPLIT)) fields_q[k] <= FIELD_RST[8*k +: 8];
          end
        end
        ST_EDIT: begin
          if (!evt.p) begin
            if (evt.r)      field_idx <= (field_idx == grp_last)  ? grp_first : field_idx + 4'd1;
            else if (evt.l) field_idx <= (field_idx == grp_first) ? grp_last  : field_idx - 4'd1;
          end
          if (step_en) begin
            for (int k = 0; k < N_FIELDS; k++) begin
              if (field_idx == 4'(k)) fields_q[k] <= stepped;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.fields_o    = fields_q;
  assign bus.state_o     = state_q;
  assign bus.field_idx_o = field_idx;
  assign bus.editing_o   = editing;
  assign bus.commit_o    = commit;

endmodule

// File: tb/tb_bcd_field_editor.sv
// Scoreboard bench for bcd_field_editor: stimulus queues each expected output snapshot
// with the cycle it must appear in; a monitor pops one per observed output change.
module tb_bcd_field_editor;

  localparam int DLY  = 20;
  localparam int RATE = 6;
  localparam int HOLD = DLY + 3 * RATE + RATE / 2;

  localparam logic [4:0] B_P = 5'b10000;
  localparam logic [4:0] B_R = 5'b01000;
  localparam logic [4:0] B_L = 5'b00100;
  localparam logic [4:0] B_U = 5'b00010;
  localparam logic [4:0] B_D = 5'b00001;

  typedef struct packed {
    logic [2:0]      st;
    logic [3:0]      idx;
    logic [8:0][7:0] f;
    logic            ed;
    logic            cm;
  } snap_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc    = 0;
  int   checks = 0;
  int   passes = 0;

  snap_t exp_q[$];
  int    due_q[$];
  string name_q[$];

  logic [2:0]      exp_st;
  logic [3:0]      exp_idx;
  logic [8:0][7:0] exp_f;

  bcd_field_editor_if #(.N_FIELDS(9)) bus ();

  bcd_field_editor #(
    .REPEAT_DLY (16'(DLY)),
    .REPEAT_RATE(16'(RATE))
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input snap_t act, input snap_t exp,
                       input int at, input int due);
    checks++;
    if (act === exp && (due < 0 || at == due)) passes++;
    else $display("FAIL %s: got st=%0d idx=%0d f=%h ed=%b cm=%b at cycle %0d, want st=%0d idx=%0d f=%h ed=%b cm=%b at cycle %0d",
                  name, act.st, act.idx, act.f, act.ed, act.cm, at,
                  exp.st, exp.idx, exp.f, exp.ed, exp.cm, due);
  endtask

  task automatic push(input string name, input int due);
    snap_t s;
    s.st  = exp_st;
    s.idx = exp_idx;
    s.f   = exp_f;
    s.ed  = (exp_st == 3'd2) || (exp_st == 3'd3);
    s.cm  = (exp_st == 3'd4);
    exp_q.push_back(s);
    due_q.push_back(due);
    name_q.push_back(name);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [4:0] m);
    {bus.BTNP, bus.BTNR, bus.BTNL, bus.BTNU, bus.BTND} = m;
  endtask

  // Raw pulse one clock wide, driven just after an edge.
  task automatic pulse(input logic [4:0] m);
    drive(m);
    tick(1);
    drive(5'b0);
  endtask

  initial begin : monitor
    snap_t last;
    snap_t cur;
    last = 'x;
    forever begin
      @(negedge clk);
      cur = {bus.state_o, bus.field_idx_o, bus.fields_o, bus.editing_o, bus.commit_o};
      if (cur !== last) begin
        last = cur;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_change: got st=%0d idx=%0d f=%h ed=%b cm=%b at cycle %0d, want no change",
                   cur.st, cur.idx, cur.f, cur.ed, cur.cm, cyc);
        end else begin
          check(name_q.pop_front(), cur, exp_q.pop_front(), cyc, due_q.pop_front());
        end
      end else if (exp_q.size() > 0 && due_q[0] >= 0 && cyc > due_q[0]) begin
        checks++;
        $display("FAIL %s: got no output change by cycle %0d, want st=%0d idx=%0d f=%h",
                 name_q[0], due_q[0], exp_q[0].st, exp_q[0].idx, exp_q[0].f);
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
        void'(name_q.pop_front());
      end
    end
  end

  initial begin : stimulus
    int         c;
    logic       up_seq [12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] val_seq[12] = '{8'h31, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                                8'h06, 8'h07, 8'h08, 8'h09, 8'h10, 8'h09};

    reset = 1'b0;
    drive(5'b0);
    bus.CTRL_Switch = 1'b0;
    exp_st  = 3'd0;
    exp_idx = 4'd0;
    exp_f   = '0;
    exp_f[0] = 8'h01;
    exp_f[1] = 8'h01;
    push("reset_state", -1);
    tick(3);
    reset = 1'b1;
    tick(2);

    // Enter clock-group edit
    c = cyc;
    exp_st = 3'd1; push("enter_sel", c + 2);
    exp_st = 3'd2; push("enter_load", c + 3);
    exp_st = 3'd3; push("enter_edit", c + 4);
    pulse(B_P);
    tick(4);

    // Field 0 (day, 01..31): wrap down, wrap up, nibble carry, nibble borrow
    for (int i = 0; i < 12; i++) begin
      c = cyc;
      exp_f[0] = val_seq[i];
      push($sformatf("day_step_%0d", i), c + 2);
      pulse(up_seq[i] ? B_U : B_D);
      tick(1);
    end
    tick(2);

    c = cyc;
    exp_st = 3'd4; push("commit_clock", c + 2);
    exp_st = 3'd0; push("idle_after_commit", c + 3);
    pulse(B_P);
    tick(4);

    // Timer group; the switch is changed after SEL to show it was latched
    bus.CTRL_Switch = 1'b1;
    c = cyc;
    exp_st = 3'd1;                 push("timer_sel", c + 2);
    exp_st = 3'd2; exp_idx = 4'd6; push("timer_load", c + 3);
    exp_st = 3'd3;                 push("timer_edit", c + 4);
    pulse(B_P);
    tick(2);
    bus.CTRL_Switch = 1'b0;
    tick(3);

    c = cyc; exp_idx = 4'd8; push("left_wrap", c + 2);  pulse(B_L); tick(2);
    c = cyc; exp_idx = 4'd6; push("right_wrap", c + 2); pulse(B_R); tick(2);
    c = cyc; exp_idx = 4'd7; push("right_step", c + 2); pulse(B_R); tick(2);
    c = cyc; exp_idx = 4'd6; push("left_step", c + 2);  pulse(B_L); tick(2);

    // Held BTNU on field 6: edge step, delayed step, then three rate steps
    c = cyc;
    exp_f[6] = 8'h01; push("hold_edge", c + 2);
    exp_f[6] = 8'h02; push("hold_delay", c + 2 + DLY);
    exp_f[6] = 8'h03; push("hold_rate1", c + 2 + DLY + RATE);
    exp_f[6] = 8'h04; push("hold_rate2", c + 2 + DLY + 2 * RATE);
    exp_f[6] = 8'h05; push("hold_rate3", c + 2 + DLY + 3 * RATE);
    drive(B_U);
    tick(HOLD);
    drive(5'b0);
    tick(DLY + 5);

    // Up and down together, held past the repeat delay: nothing may change
    drive(B_U | B_D);
    tick(DLY + 10);
    drive(5'b0);
    tick(5);

    // Program beats next-field in the same cycle
    c = cyc;
    exp_st = 3'd4; push("commit_over_right", c + 2);
    exp_st = 3'd0; push("commit_one_cycle", c + 3);
    pulse(B_P | B_R);
    tick(4);

    // Re-enter clock edit: LOAD reverts the clock group only
    c = cyc;
    exp_st = 3'd1;                                    push("reedit_sel", c + 2);
    exp_st = 3'd2; exp_idx = 4'd0;                    push("reedit_load", c + 3);
    exp_st = 3'd3; exp_f[0] = 8'h01; exp_f[2] = 8'h00; push("reedit_revert", c + 4);
    pulse(B_P);
    tick(4);
    c = cyc; exp_f[0] = 8'h02; push("reedit_step", c + 2); pulse(B_U); tick(3);

    // Reset mid-edit: immediate IDLE, load values, no commit pulse
    c = cyc;
    exp_st  = 3'd0;
    exp_idx = 4'd0;
    exp_f   = '0;
    exp_f[0] = 8'h01;
    exp_f[1] = 8'h01;
    push("abort_reset", c);
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(10);

    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: got %0d outstanding expectations, want 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
